fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
- REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
- REQ-002 SHALL have parameter DEPTH, default 4, meaning queue entries; legal values are powers of two from 2 to 16.
- REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
- REQ-004 reset  input  1  asynchronous, active-high reset.
- REQ-005 bj_taken_i  input  1  redirect request from execute.
- REQ-006 bj_target_i  input  32  redirect target address.
- REQ-007 inst_req_o  output  1  fetch request to instruction memory.
- REQ-008 inst_addr_o  output  32  fetch address, always word-aligned.
- REQ-009 inst_gnt_i  input  1  memory accepts the request when inst_req_o & inst_gnt_i.
- REQ-010 inst_rvalid_i  input  1  response valid; responses return in request order, latency >= 1 cycle.
- REQ-011 inst_rdata_i  input  32  response instruction word.
- REQ-012 f_to_d_valid  output  1  head entry is available to decode.
- REQ-013 f_to_d_ready  input  1  decode accepts the head entry.
- REQ-014 f_to_d_bus  output  64  {pc[63:32], inst[31:0]} of the head entry.

Function
- REQ-015 SHALL hold fetch_pc; inst_addr_o = fetch_pc with bits [1:0] forced to 0.
- REQ-016 Each entry SHALL be {pc, inst, filled}. An entry is allocated at the tail with pc = fetch_pc on issue (req & gnt) and filled on inst_rvalid_i.
- REQ-017 On issue, fetch_pc SHALL advance by 4 (wraps modulo 2^32).
- REQ-018 inst_req_o = !bj_taken_i & (allocated + discard_cnt < DEPTH); it SHALL be combinational from registered state and bj_taken_i only.
- REQ-019 An inst_rvalid_i pulse with discard_cnt == 0 SHALL write inst_rdata_i into the oldest unfilled entry and set its filled bit.
- REQ-020 f_to_d_valid = head entry allocated & filled & !bj_taken_i. Latency is one cycle from inst_rvalid_i to f_to_d_valid.
- REQ-021 Pop SHALL occur on f_to_d_valid & f_to_d_ready, advancing the head; f_to_d_bus SHALL be don't-care when f_to_d_valid is low.
- REQ-022 Issue, fill and pop in the same cycle SHALL all take effect; a full queue (allocated == DEPTH) that pops SHALL still block issue that cycle, because inst_req_o uses registered counts.
- REQ-023 Redirect: when bj_taken_i is high, the module SHALL:
  - set fetch_pc <= {bj_target_i[31:2], 2'b00};
  - free all entries (head, tail and fill pointers equal, allocated = 0);
  - set discard_cnt <= (entries issued but unfilled) - (inst_rvalid_i ? 1 : 0) + discard_cnt.
  Any pop or issue in that cycle SHALL be suppressed.
- REQ-024 While discard_cnt > 0, each inst_rvalid_i SHALL decrement discard_cnt and drop the data.
- REQ-025 Redirects in consecutive cycles SHALL each retarget fetch_pc; the last one wins and discard accounting stays exact.
- REQ-026 Pointers SHALL be log2(DEPTH) bits wrapping modulo DEPTH. The allocated count and discard_cnt SHALL be log2(DEPTH)+1 bits, and allocated + discard_cnt never exceeds DEPTH.
- REQ-027 inst_rvalid_i with no issued-unfilled entry and discard_cnt == 0 is illegal; assertion only, no RTL effect.

Reset
- REQ-028 reset high SHALL immediately clear all entries, pointers, allocated count and discard_cnt, and set fetch_pc = RESET_PC.
- REQ-029 During reset: inst_req_o = 0 and f_to_d_valid = 0.
- REQ-030 Reset mid-operation SHALL abandon in-flight requests; the memory model is reset concurrently.
- REQ-031 The first request after reset release SHALL appear in the first cycle with reset low, with address RESET_PC.

Verification
- REQ-032 Reset release, gnt=1, 1-cycle memory, ready=1: addresses 0x0,0x4,0x8,...; decode sees pc 0x0 two cycles after first request, then one entry per cycle.
- REQ-033 DEPTH=4, ready=0: exactly 4 issues then inst_req_o=0. Then ready=1 for one cycle: one pop, next cycle one issue, at address 0x10.
- REQ-034 3 requests outstanding (latency 5), redirect to 0x1003: next address 0x1000, the 3 stale responses are dropped, and the first f_to_d_bus pc = 0x1000.
- REQ-035 Redirect in the same cycle as an rvalid with 2 outstanding: discard_cnt=1; exactly one later response is dropped.
- REQ-036 fetch_pc=0xFFFF_FFFC issue: next address 0x0000_0000.
- REQ-037 Assert reset asynchronously mid-burst: outputs drop without a clock edge; after release, the first address is RESET_PC.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential word fetches, collects in-order
// memory responses and presents {pc, inst} entries to decode, with redirect flush.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bj_taken_i,
  input  logic [31:0] bj_target_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_gnt_i,
  input  logic        inst_rvalid_i,
  input  logic [31:0] inst_rdata_i,
  output logic        f_to_d_valid,
  input  logic        f_to_d_ready,
  output logic [63:0] f_to_d_bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(DEPTH);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] alloc_q, alloc_d;
  logic [CNT_W-1:0] unfilled_q, unfilled_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      pc_d   [DEPTH];
  logic [31:0]      inst_q [DEPTH];
  logic [31:0]      inst_d [DEPTH];

  logic             issue;
  logic             fill_en;
  logic             drop;
  logic             pop;
  logic [CNT_W:0]   occupancy;
  logic [1:0]       unused_target_lsbs;

  assign unused_target_lsbs = bj_target_i[1:0];

  // Slots held by stale in-flight responses count against capacity so that a
  // late response can never land in a freshly allocated entry.
  always_comb begin
    occupancy    = {1'b0, alloc_q} + {1'b0, discard_q};
    inst_req_o   = !reset && !bj_taken_i && (occupancy < DEPTH_W);
    inst_addr_o  = {fetch_pc_q[31:2], 2'b00};
    issue        = inst_req_o && inst_gnt_i;
    fill_en      = inst_rvalid_i && (discard_q == '0);
    drop         = inst_rvalid_i && (discard_q != '0);
    f_to_d_valid = !reset && !bj_taken_i && (alloc_q != '0) && filled_q[head_q];
    pop          = f_to_d_valid && f_to_d_ready;
    f_to_d_bus   = {pc_q[head_q], inst_q[head_q]};
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    fill_d     = fill_q;
    alloc_d    = alloc_q;
    unfilled_d = unfilled_q;
    discard_d  = discard_q;
    filled_d   = filled_q;
    pc_d       = pc_q;
    inst_d     = inst_q;

    if (bj_taken_i) begin
      // Every issued-but-unfilled entry becomes a response to throw away; one
      // arriving this very cycle is already accounted for.
      fetch_pc_d = {bj_target_i[31:2], 2'b00};
      head_d     = tail_q;
      fill_d     = tail_q;
      alloc_d    = '0;
      unfilled_d = '0;
      discard_d  = discard_q + unfilled_q - CNT_W'(inst_rvalid_i);
    end else begin
      if (issue) begin
        pc_d[tail_q]     = fetch_pc_q;
        filled_d[tail_q] = 1'b0;
        tail_d           = tail_q + PTR_W'(1);
        fetch_pc_d       = fetch_pc_q + 32'd4;
      end
      if (fill_en) begin
        inst_d[fill_q]   = inst_rdata_i;
        filled_d[fill_q] = 1'b1;
        fill_d           = fill_q + PTR_W'(1);
      end
      if (drop) begin
        discard_d = discard_q - CNT_W'(1);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      alloc_d    = alloc_q + CNT_W'(issue) - CNT_W'(pop);
      unfilled_d = unfilled_q + CNT_W'(issue) - CNT_W'(fill_en);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      alloc_q    <= '0;
      unfilled_q <= '0;
      discard_q  <= '0;
      filled_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      fill_q     <= fill_d;
      alloc_q    <= alloc_d;
      unfilled_q <= unfilled_d;
      discard_q  <= discard_d;
      filled_q   <= filled_d;
    end
  end

  // Payload storage needs no reset; validity lives in the counters and filled bits.
  always_ff @(posedge clk) begin
    pc_q   <= pc_d;
    inst_q <= inst_d;
  end

  rvalid_has_owner: assert property (@(posedge clk) disable iff (reset)
    inst_rvalid_i |-> ((unfilled_q != '0) || (discard_q != '0)));

  occupancy_bound: assert property (@(posedge clk) disable iff (reset)
    occupancy <= DEPTH_W);

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized scoreboard bench for fetch_queue: an in-order memory model with
// stale-response tracking predicts requests, addresses and decode payloads.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        bj_taken_i;
  logic [31:0] bj_target_i;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_gnt_i;
  logic        inst_rvalid_i;
  logic [31:0] inst_rdata_i;
  logic        f_to_d_valid;
  logic        f_to_d_ready;
  logic [63:0] f_to_d_bus;

  fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .bj_taken_i   (bj_taken_i),
    .bj_target_i  (bj_target_i),
    .inst_req_o   (inst_req_o),
    .inst_addr_o  (inst_addr_o),
    .inst_gnt_i   (inst_gnt_i),
    .inst_rvalid_i(inst_rvalid_i),
    .inst_rdata_i (inst_rdata_i),
    .f_to_d_valid (f_to_d_valid),
    .f_to_d_ready (f_to_d_ready),
    .f_to_d_bus   (f_to_d_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          readyCyc;
    bit          stale;
  } memRsp_t;

  memRsp_t     pendingQ[$];
  logic [63:0] sbQ[$];
  logic [31:0] modelPc;
  int          allocM;
  int          lastReadyCyc;
  int          cyc;
  int          gntPct, readyPct, bjPct, latMin, latMax;
  int          issueCount, popCount, firstIssueCyc, firstPopCyc;
  logic [31:0] lastIssueAddr, firstPopPc;
  int          testsRun = 0;
  int          testsFailed = 0;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int staleCount();
    int n = 0;
    foreach (pendingQ[i]) if (pendingQ[i].stale) n++;
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Memory model and request-side reference: decides what the fetch unit may
  // request, which address it must use, and what decode should eventually see.
  initial begin
    inst_gnt_i    = 1'b0;
    inst_rvalid_i = 1'b0;
    inst_rdata_i  = '0;
    cyc           = 0;
    lastReadyCyc  = -1;
    modelPc       = RESET_PC;
    allocM        = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pendingQ.delete();
        sbQ.delete();
        modelPc      = RESET_PC;
        allocM       = 0;
        lastReadyCyc = -1;
      end else begin
        checkOutput("inst_req_o", 64'(inst_req_o),
                    64'(!bj_taken_i && (allocM + staleCount() < int'(DEPTH))));
        if (inst_rvalid_i && pendingQ.size() > 0) void'(pendingQ.pop_front());
        if (bj_taken_i) begin
          foreach (pendingQ[i]) pendingQ[i].stale = 1'b1;
          sbQ.delete();
          allocM  = 0;
          modelPc = {bj_target_i[31:2], 2'b00};
        end else begin
          if (inst_req_o && inst_gnt_i) begin
            memRsp_t rsp;
            int lat;
            checkOutput("inst_addr_o", 64'(inst_addr_o), 64'(modelPc));
            lat          = int'($urandom_range(latMax, latMin));
            rsp.data     = memWord(modelPc);
            rsp.readyCyc = (cyc + lat > lastReadyCyc + 1) ? cyc + lat : lastReadyCyc + 1;
            rsp.stale    = 1'b0;
            lastReadyCyc = rsp.readyCyc;
            pendingQ.push_back(rsp);
            sbQ.push_back({modelPc, memWord(modelPc)});
            if (firstIssueCyc < 0) firstIssueCyc = cyc;
            issueCount++;
            lastIssueAddr = modelPc;
            allocM++;
            modelPc = modelPc + 32'd4;
          end
          if (f_to_d_valid && f_to_d_ready) allocM--;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      inst_gnt_i = ($urandom_range(99, 0) < gntPct);
      if (pendingQ.size() > 0 && pendingQ[0].readyCyc <= cyc) begin
        inst_rvalid_i = 1'b1;
        inst_rdata_i  = pendingQ[0].data;
      end else begin
        inst_rvalid_i = 1'b0;
        inst_rdata_i  = $urandom;
      end
    end
  end

  // Decode-side monitor: every accepted entry must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bj_taken_i) checkOutput("valid_during_redirect", 64'(f_to_d_valid), 64'd0);
        if (f_to_d_valid && f_to_d_ready) begin
          popCount++;
          if (firstPopCyc < 0) begin
            firstPopCyc = cyc;
            firstPopPc  = f_to_d_bus[63:32];
          end
          if (sbQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL unexpected_pop: got bus 0x%0h, expected no entry", f_to_d_bus);
          end else begin
            checkOutput("f_to_d_bus", f_to_d_bus, sbQ.pop_front());
          end
        end
      end
    end
  end

  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      f_to_d_ready = ($urandom_range(99, 0) < readyPct);
      bj_taken_i   = ($urandom_range(99, 0) < bjPct);
      bj_target_i  = ($urandom_range(9, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
    end
  endtask

  task automatic doRedirect(input logic [31:0] target);
    @(posedge clk);
    #1;
    bj_taken_i   = 1'b1;
    bj_target_i  = target;
    f_to_d_ready = ($urandom_range(99, 0) < readyPct);
    popCount     = 0;
    firstPopCyc  = -1;
  endtask

  task automatic assertReset();
    @(posedge clk);
    #1;
    reset      = 1'b1;
    bj_taken_i = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic releaseReset();
    @(posedge clk);
    #1;
    reset         = 1'b0;
    bj_taken_i    = 1'b0;
    f_to_d_ready  = ($urandom_range(99, 0) < readyPct);
    issueCount    = 0;
    popCount      = 0;
    firstIssueCyc = -1;
    firstPopCyc   = -1;
    #1;
    checkOutput("first_req_after_reset", 64'(inst_req_o), 64'd1);
    checkOutput("first_addr_after_reset", 64'(inst_addr_o), 64'(RESET_PC));
  endtask

  initial begin
    reset        = 1'b1;
    bj_taken_i   = 1'b0;
    bj_target_i  = '0;
    f_to_d_ready = 1'b0;
    gntPct = 100; readyPct = 0; bjPct = 0; latMin = 1; latMax = 1;
    issueCount = 0; popCount = 0; firstIssueCyc = -1; firstPopCyc = -1;
    lastIssueAddr = '0; firstPopPc = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_req", 64'(inst_req_o), 64'd0);
    checkOutput("reset_valid", 64'(f_to_d_valid), 64'd0);

    // Decode stalled: queue fills to DEPTH, then one pop frees exactly one slot.
    releaseReset();
    applyStimulus(8);
    @(negedge clk); #1;
    checkOutput("full_issue_count", 64'(issueCount), 64'(DEPTH));
    checkOutput("full_req_low", 64'(inst_req_o), 64'd0);
    readyPct = 100;
    applyStimulus(1);
    readyPct = 0;
    applyStimulus(3);
    @(negedge clk); #1;
    checkOutput("refill_issue_count", 64'(issueCount), 64'(DEPTH + 1));
    checkOutput("refill_addr", 64'(lastIssueAddr), 64'h10);
    checkOutput("single_pop", 64'(popCount), 64'd1);

    // Streaming with a one-cycle memory: two-cycle fetch-to-decode latency.
    assertReset();
    readyPct = 100;
    releaseReset();
    applyStimulus(11);
    @(negedge clk); #1;
    checkOutput("stream_latency", 64'(firstPopCyc - firstIssueCyc), 64'd2);
    checkOutput("stream_issues", 64'(issueCount), 64'd12);
    checkOutput("stream_pops", 64'(popCount), 64'd10);

    // Redirect with three long-latency requests in flight.
    assertReset();
    latMin = 5; latMax = 5;
    releaseReset();
    applyStimulus(2);
    doRedirect(32'h0000_1003);
    applyStimulus(20);
    @(negedge clk); #1;
    checkOutput("redirect_first_pc", 64'(firstPopPc), 64'h1000);

    // Redirect coinciding with a response while two requests are outstanding.
    assertReset();
    latMin = 2; latMax = 2;
    releaseReset();
    applyStimulus(1);
    doRedirect(32'h0000_2000);
    applyStimulus(12);
    @(negedge clk); #1;
    checkOutput("redirect_rvalid_first_pc", 64'(firstPopPc), 64'h2000);

    // Fetch address wraps past the top of the address space.
    latMin = 1; latMax = 1;
    doRedirect(32'hFFFF_FFF8);
    applyStimulus(3);
    @(negedge clk); #1;
    checkOutput("wrap_addr", 64'(lastIssueAddr), 64'h0);
    applyStimulus(5);

    // Long randomized run with back-pressure, grant gaps and frequent redirects.
    assertReset();
    gntPct = 70; readyPct = 60; bjPct = 6; latMin = 1; latMax = 6;
    releaseReset();
    applyStimulus(3000);

    // Asynchronous reset in the middle of a burst.
    gntPct = 100; readyPct = 50; bjPct = 0;
    applyStimulus(20);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_req", 64'(inst_req_o), 64'd0);
    checkOutput("async_reset_valid", 64'(f_to_d_valid), 64'd0);
    repeat (2) @(posedge clk);
    releaseReset();
    applyStimulus(40);

    // Stop issuing and let every expected entry reach decode.
    gntPct = 0; readyPct = 100; bjPct = 0;
    for (int i = 0; i < 80; i++) begin
      applyStimulus(1);
      if (sbQ.size() == 0 && pendingQ.size() == 0) break;
    end
    @(negedge clk); #1;
    checkOutput("drain_scoreboard", 64'(sbQ.size()), 64'd0);
    checkOutput("drain_memory", 64'(pendingQ.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
